// File: rtl/crop_box_scheduler.sv
// Shares one crop_filter between two requesters: round-robin box grant, crop origin load,
// pixel counting to end of frame, then filter re-arm and owner report.
module crop_box_scheduler #(
    parameter int unsigned IN_ROWS          = 40,
    parameter int unsigned IN_COLS          = 40,
    parameter int unsigned OUT_ROWS         = 20,
    parameter int unsigned OUT_COLS         = 20,
    parameter int unsigned IMG_ROW_BITWIDTH = 10,
    parameter int unsigned IMG_COL_BITWIDTH = 10,
    parameter int unsigned PIX_CNT_BITWIDTH = 21
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] req0_TDATA,
    input  logic                                         req0_TVALID,
    output logic                                         req0_TREADY,
    input  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] req1_TDATA,
    input  logic                                         req1_TVALID,
    output logic                                         req1_TREADY,
    output logic [IMG_ROW_BITWIDTH-1:0]                  crop_Y1_TDATA,
    output logic                                         crop_Y1_TVALID,
    input  logic                                         crop_Y1_TREADY,
    output logic [IMG_COL_BITWIDTH-1:0]                  crop_X1_TDATA,
    output logic                                         crop_X1_TVALID,
    input  logic                                         crop_X1_TREADY,
    input  logic                                         pix_TVALID,
    input  logic                                         pix_TREADY,
    output logic                                         crop_rearm,
    output logic                                         frame_done,
    output logic                                         frame_owner,
    output logic                                         busy
);

    localparam int unsigned R = IMG_ROW_BITWIDTH;
    localparam int unsigned C = IMG_COL_BITWIDTH;
    localparam int unsigned W = R + C;
    localparam int unsigned P = PIX_CNT_BITWIDTH;

    localparam logic [R-1:0] Y1_MAX   = R'(IN_ROWS - OUT_ROWS);
    localparam logic [C-1:0] X1_MAX   = C'(IN_COLS - OUT_COLS);
    localparam logic [P-1:0] PIX_LAST = P'(IN_ROWS * IN_COLS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           arm_q;
    logic           rr_last_q, rr_last_d;
    logic           owner_q, owner_d;
    logic [P-1:0]   pix_cnt_q, pix_cnt_d;
    logic [R-1:0]   y1_d, req_y;
    logic [C-1:0]   x1_d, req_x;
    logic           y_vld_d, x_vld_d;
    logic           rearm_d, done_d, fowner_d, busy_d;
    logic           gnt0, gnt1;

    // arm_q keeps both TREADYs low until the first clock after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            arm_q          <= 1'b0;
            rr_last_q      <= 1'b1;
            owner_q        <= 1'b0;
            pix_cnt_q      <= '0;
            crop_Y1_TDATA  <= '0;
            crop_X1_TDATA  <= '0;
            crop_Y1_TVALID <= 1'b0;
            crop_X1_TVALID <= 1'b0;
            crop_rearm     <= 1'b0;
            frame_done     <= 1'b0;
            frame_owner    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            arm_q          <= 1'b1;
            rr_last_q      <= rr_last_d;
            owner_q        <= owner_d;
            pix_cnt_q      <= pix_cnt_d;
            crop_Y1_TDATA  <= y1_d;
            crop_X1_TDATA  <= x1_d;
            crop_Y1_TVALID <= y_vld_d;
            crop_X1_TVALID <= x_vld_d;
            crop_rearm     <= rearm_d;
            frame_done     <= done_d;
            frame_owner    <= fowner_d;
            busy           <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        owner_d   = owner_q;
        pix_cnt_d = pix_cnt_q;
        y1_d      = crop_Y1_TDATA;
        x1_d      = crop_X1_TDATA;
        y_vld_d   = crop_Y1_TVALID;
        x_vld_d   = crop_X1_TVALID;
        rearm_d   = 1'b0;
        done_d    = 1'b0;
        fowner_d  = frame_owner;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        req_y     = '0;
        req_x     = '0;

        case (state_q)
            IDLE: begin
                // round-robin: on contention the requester not served last wins
                gnt0  = arm_q & req0_TVALID & (~req1_TVALID | rr_last_q);
                gnt1  = arm_q & req1_TVALID & (~req0_TVALID | ~rr_last_q);
                req_y = gnt1 ? req1_TDATA[W-1:C] : req0_TDATA[W-1:C];
                req_x = gnt1 ? req1_TDATA[C-1:0] : req0_TDATA[C-1:0];
                if (gnt0 | gnt1) begin
                    y1_d      = (req_y > Y1_MAX) ? Y1_MAX : req_y;
                    x1_d      = (req_x > X1_MAX) ? X1_MAX : req_x;
                    y_vld_d   = 1'b1;
                    x_vld_d   = 1'b1;
                    rr_last_d = gnt1;
                    owner_d   = gnt1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                y_vld_d = crop_Y1_TVALID & ~crop_Y1_TREADY;
                x_vld_d = crop_X1_TVALID & ~crop_X1_TREADY;
                if (!y_vld_d && !x_vld_d) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pix_TVALID && pix_TREADY) begin
                    if (pix_cnt_q == PIX_LAST) begin
                        pix_cnt_d = '0;
                        done_d    = 1'b1;
                        rearm_d   = 1'b1;
                        fowner_d  = owner_q;
                        state_d   = DONE;
                    end else begin
                        pix_cnt_d = pix_cnt_q + P'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign req0_TREADY = gnt0;
    assign req1_TREADY = gnt1;

endmodule

// File: tb/tb_crop_box_scheduler.sv
// Bench for crop_box_scheduler: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_crop_box_scheduler;

    localparam int FRAME = 1600;
    localparam int YMAX  = 20;
    localparam int XMAX  = 20;

    logic        clk;
    logic        reset;
    logic [19:0] req0_TDATA, req1_TDATA;
    logic        req0_TVALID, req0_TREADY, req1_TVALID, req1_TREADY;
    logic [9:0]  crop_Y1_TDATA, crop_X1_TDATA;
    logic        crop_Y1_TVALID, crop_Y1_TREADY, crop_X1_TVALID, crop_X1_TREADY;
    logic        pix_TVALID, pix_TREADY;
    logic        crop_rearm, frame_done, frame_owner, busy;

    int n_cmp = 0;
    int n_err = 0;

    crop_box_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .req0_TDATA     (req0_TDATA),
        .req0_TVALID    (req0_TVALID),
        .req0_TREADY    (req0_TREADY),
        .req1_TDATA     (req1_TDATA),
        .req1_TVALID    (req1_TVALID),
        .req1_TREADY    (req1_TREADY),
        .crop_Y1_TDATA  (crop_Y1_TDATA),
        .crop_Y1_TVALID (crop_Y1_TVALID),
        .crop_Y1_TREADY (crop_Y1_TREADY),
        .crop_X1_TDATA  (crop_X1_TDATA),
        .crop_X1_TVALID (crop_X1_TVALID),
        .crop_X1_TREADY (crop_X1_TREADY),
        .pix_TVALID     (pix_TVALID),
        .pix_TREADY     (pix_TREADY),
        .crop_rearm     (crop_rearm),
        .frame_done     (frame_done),
        .frame_owner    (frame_owner),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 loading box, 2 counting pixels, 3 done pulse
    int m_phase, m_last, m_owner, m_y, m_x, m_left;
    bit m_yv, m_xv, m_arm;

    task automatic m_reset();
        m_phase = 0; m_last = 1; m_owner = 0; m_y = 0; m_x = 0;
        m_yv = 0; m_xv = 0; m_arm = 0; m_left = FRAME;
    endtask

    task automatic m_step();
        int w;
        logic [19:0] d;
        case (m_phase)
            0: if (m_arm && (req0_TVALID || req1_TVALID)) begin
                if (req0_TVALID && req1_TVALID) w = 1 - m_last;
                else w = req0_TVALID ? 0 : 1;
                d = (w == 0) ? req0_TDATA : req1_TDATA;
                m_y = (int'(d[19:10]) > YMAX) ? YMAX : int'(d[19:10]);
                m_x = (int'(d[9:0]) > XMAX) ? XMAX : int'(d[9:0]);
                m_yv = 1; m_xv = 1;
                m_owner = w; m_last = w;
                m_phase = 1;
            end
            1: begin
                if (m_yv && crop_Y1_TREADY) m_yv = 0;
                if (m_xv && crop_X1_TREADY) m_xv = 0;
                if (!m_yv && !m_xv) m_phase = 2;
            end
            2: if (pix_TVALID && pix_TREADY) begin
                m_left--;
                if (m_left == 0) begin
                    m_left = FRAME;
                    m_phase = 3;
                end
            end
            default: m_phase = 0;
        endcase
        m_arm = 1;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_reset();
            else m_step();
        end
    end

    // Per-cycle comparison of every DUT output against the model
    initial begin
        bit e0, e1;
        forever begin
            @(negedge clk);
            e0 = 0; e1 = 0;
            if (m_arm && m_phase == 0) begin
                if (req0_TVALID && req1_TVALID) begin
                    e0 = (m_last == 1);
                    e1 = !e0;
                end else begin
                    e0 = req0_TVALID;
                    e1 = req1_TVALID;
                end
            end
            chk("req0_TREADY", req0_TREADY, e0);
            chk("req1_TREADY", req1_TREADY, e1);
            chk("single_ready", req0_TREADY & req1_TREADY, 0);
            chk("crop_Y1_TVALID", crop_Y1_TVALID, m_yv);
            chk("crop_X1_TVALID", crop_X1_TVALID, m_xv);
            chk("crop_Y1_TDATA", crop_Y1_TDATA, m_y);
            chk("crop_X1_TDATA", crop_X1_TDATA, m_x);
            chk("busy", busy, m_phase != 0);
            chk("frame_done", frame_done, m_phase == 3);
            chk("crop_rearm", crop_rearm, m_phase == 3);
            if (m_phase == 3) chk("frame_owner", frame_owner, m_owner);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic feed(input int n, input bit rnd);
        int cnt = 0;
        while (cnt < n) begin
            pix_TVALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_TVALID && pix_TREADY) cnt++;
            step();
        end
        pix_TVALID = 1'b0;
        pix_TREADY = 1'b0;
    endtask

    task automatic expect_done(input int owner);
        #1;
        chk("done_pulse", frame_done, 1);
        chk("done_rearm", crop_rearm, 1);
        chk("done_owner", frame_owner, owner);
        step();
        #1;
        chk("done_width", frame_done, 0);
        chk("done_idle_busy", busy, 0);
    endtask

    task automatic wait_grant(output int id);
        id = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_TREADY) begin id = 0; break; end
            if (req1_TREADY) begin id = 1; break; end
            step();
        end
        if (id < 0) chk("grant_timeout", 0, 1);
    endtask

    initial begin
        int id;
        int exp_ord [3];
        exp_ord = '{0, 1, 0};

        reset = 1'b0;
        req0_TDATA = '0; req0_TVALID = 1'b0;
        req1_TDATA = '0; req1_TVALID = 1'b0;
        crop_Y1_TREADY = 1'b1; crop_X1_TREADY = 1'b1;
        pix_TVALID = 1'b0; pix_TREADY = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_yvld", crop_Y1_TVALID, 0);
        chk("rst_xvld", crop_X1_TVALID, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ydata", crop_Y1_TDATA, 0);
        step();
        reset = 1'b1;
        step();

        // pixel handshakes while idle are ignored
        pix_TVALID = 1'b1; pix_TREADY = 1'b1;
        step(); step();
        pix_TVALID = 1'b0; pix_TREADY = 1'b0;

        // single req0 frame
        req0_TDATA = {10'd5, 10'd7};
        req0_TVALID = 1'b1;
        #1;
        chk("t1_ready0", req0_TREADY, 1);
        chk("t1_ready1", req1_TREADY, 0);
        step();
        req0_TVALID = 1'b0;
        #1;
        chk("t1_y1", crop_Y1_TDATA, 5);
        chk("t1_x1", crop_X1_TDATA, 7);
        chk("t1_yvld", crop_Y1_TVALID, 1);
        chk("t1_xvld", crop_X1_TVALID, 1);
        chk("t1_busy", busy, 1);
        step();
        feed(FRAME, 0);
        expect_done(0);

        // contention over three frames after a fresh reset
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        req0_TDATA = {10'd1, 10'd2};
        req1_TDATA = {10'd30, 10'd25};
        req0_TVALID = 1'b1;
        req1_TVALID = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_grant(id);
            chk("t2_grant_order", id, exp_ord[f]);
            step();
            step();
            feed(FRAME, 0);
            expect_done(exp_ord[f]);
        end
        req0_TVALID = 1'b0;
        req1_TVALID = 1'b0;

        // clamp, X1 stall in LOAD with ignored pixels, random pixel backpressure
        req1_TDATA = {10'd35, 10'd39};
        req1_TVALID = 1'b1;
        wait_grant(id);
        chk("t3_grant", id, 1);
        step();
        req1_TVALID = 1'b0;
        crop_X1_TREADY = 1'b0;
        #1;
        chk("t3_clamp_y", crop_Y1_TDATA, 20);
        chk("t3_clamp_x", crop_X1_TDATA, 20);
        step();
        for (int i = 0; i < 4; i++) begin
            pix_TVALID = 1'b1;
            pix_TREADY = 1'b1;
            #1;
            chk("t3_stall_yvld", crop_Y1_TVALID, 0);
            chk("t3_stall_xvld", crop_X1_TVALID, 1);
            chk("t3_stall_xdata", crop_X1_TDATA, 20);
            step();
        end
        crop_X1_TREADY = 1'b1;
        pix_TVALID = 1'b0;
        pix_TREADY = 1'b0;
        step();
        feed(FRAME, 1);
        expect_done(1);

        // reset mid-frame abandons it; a fresh frame follows
        req0_TDATA = {10'd0, 10'd0};
        req0_TVALID = 1'b1;
        wait_grant(id);
        chk("t4_grant", id, 0);
        step();
        req0_TVALID = 1'b0;
        step();
        feed(800, 0);
        req0_TDATA = {10'd2, 10'd3};
        req0_TVALID = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_ready", req0_TREADY, 0);
        chk("t4_rst_done", frame_done, 0);
        chk("t4_rst_rearm", crop_rearm, 0);
        chk("t4_rst_ydata", crop_Y1_TDATA, 0);
        step();
        step();
        reset = 1'b1;
        wait_grant(id);
        chk("t4_regrant", id, 0);
        step();
        req0_TVALID = 1'b0;
        #1;
        chk("t4_y1", crop_Y1_TDATA, 2);
        chk("t4_x1", crop_X1_TDATA, 3);
        step();
        feed(FRAME, 1);
        expect_done(0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
